// File: rtl/dmem_wbuf.sv
// Posted-write buffer between the core load/store port and the L1 data cache.
// Writes are queued in a circular FIFO and drained in order; reads bypass the
// queue unless they hit a pending word, in which case they wait for the drain.
// A write to the youngest entry's word merges into that entry.
module dmem_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_wr,
    input  logic [AW-1:0] core_addr,
    input  logic [3:0]    core_byte,
    input  logic [31:0]   core_wdata,
    output logic [31:0]   core_rdata,
    output logic          core_busy,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_byte,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_busy,
    output logic          wbuf_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = AW - 2;

    typedef struct packed {
        logic [WW-1:0] waddr;
        logic [3:0]    strb;
        logic [31:0]   data;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    head_d;
    logic [PW-1:0]    tail_q;
    logic [PW-1:0]    tail_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic [WW-1:0]    core_word_c;
    logic [PW-1:0]    young_c;
    logic             is_rd_c;
    logic             is_wr_c;
    logic             hazard_c;
    logic             full_c;
    logic             merge_c;
    logic             head_merge_c;
    logic             rd_pass_c;
    logic             drain_c;
    logic             deq_c;
    logic             enq_c;

    assign core_word_c = core_addr[AW-1:2];
    assign young_c     = tail_q - PW'(1);
    assign is_rd_c     = !rst && core_req && !core_wr;
    assign is_wr_c     = !rst && core_req && core_wr;
    assign full_c      = (count_q == CW'(DEPTH));

    // Read hazard: the requested word is still sitting in the buffer.
    always_comb begin
        hazard_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[PW'(i)] && (ent_q[PW'(i)].waddr == core_word_c)) begin
                hazard_c = 1'b1;
            end
        end
    end

    // Arbitration between read pass-through, write merge/enqueue and drain.
    // A merge into the head entry withholds the drain for that cycle so the
    // cache never sees head fields change under an outstanding request.
    always_comb begin
        merge_c      = is_wr_c && (count_q != '0) && (ent_q[young_c].waddr == core_word_c);
        head_merge_c = merge_c && (count_q == CW'(1));
        rd_pass_c    = is_rd_c && !hazard_c;
        drain_c      = !rst && (count_q != '0) && !rd_pass_c && !head_merge_c;
        deq_c        = drain_c && !mem_busy;
        enq_c        = is_wr_c && !merge_c && !full_c;
    end

    // Core-side handshake; read data is a straight pass from the cache.
    always_comb begin
        core_busy  = 1'b0;
        core_rdata = mem_rdata;
        if (rst) begin
            core_busy = 1'b1;
        end else if (core_req) begin
            if (core_wr) begin
                core_busy = !merge_c && full_c;
            end else begin
                core_busy = hazard_c || mem_busy;
            end
        end
    end

    // Cache-side request: read pass-through wins, otherwise present the head.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = {ent_q[head_q].waddr, 2'b00};
        mem_byte  = ent_q[head_q].strb;
        mem_wdata = ent_q[head_q].data;
        if (rd_pass_c) begin
            mem_req  = 1'b1;
            mem_addr = core_addr;
            mem_byte = core_byte;
        end else if (drain_c) begin
            mem_req = 1'b1;
            mem_wr  = 1'b1;
        end
    end

    assign wbuf_empty = (count_q == '0);

    // Next-state for the FIFO: dequeue at head, enqueue at tail, merge into youngest.
    always_comb begin
        ent_d   = ent_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq_c) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (enq_c) begin
            ent_d[tail_q].waddr = core_word_c;
            ent_d[tail_q].strb  = core_byte;
            ent_d[tail_q].data  = core_wdata;
            valid_d[tail_q]     = 1'b1;
            tail_d              = tail_q + PW'(1);
        end
        if (merge_c) begin
            ent_d[young_c].strb = ent_q[young_c].strb | core_byte;
            for (int unsigned b = 0; b < 4; b++) begin
                if (core_byte[2'(b)]) begin
                    ent_d[young_c].data[8*b +: 8] = core_wdata[8*b +: 8];
                end
            end
        end
        if (enq_c && !deq_c) begin
            count_d = count_q + CW'(1);
        end else if (deq_c && !enq_c) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO state registers; reset discards every pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[PW'(i)] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf with a cache model and expected-transaction queues.
module tb_dmem_wbuf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req;
    logic          core_wr;
    logic [AW-1:0] core_addr;
    logic [3:0]    core_byte;
    logic [31:0]   core_wdata;
    logic [31:0]   core_rdata;
    logic          core_busy;
    logic          mem_req;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_byte;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_busy;
    logic          wbuf_empty;

    dmem_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
        .core_byte(core_byte), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_busy(core_busy),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_byte(mem_byte),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .wbuf_empty(wbuf_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [68:0] exp_mem [$];
    logic [31:0] exp_rd  [$];
    logic [31:0] cache [int unsigned];
    logic [31:0] gold  [int unsigned];

    logic        core_rd_pend = 1'b0;
    logic        mrd_pend     = 1'b0;
    logic [31:0] mrd_val      = 32'h0;
    logic        rand_busy    = 1'b0;
    logic [68:0] mon_obs;
    logic [68:0] mon_exp;
    logic [31:0] mon_rexp;
    logic [31:0] mon_old;

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [68:0] mk(input logic wr, input logic [31:0] a,
                                       input logic [3:0] be, input logic [31:0] d);
        return {wr, a, be, wr ? d : 32'h0};
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        return gold.exists(a[31:2]) ? gold[a[31:2]] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Cache model and scoreboard: compare every cache transfer and every read return.
    always @(negedge clk) begin
        if (core_rd_pend) begin
            core_rd_pend = 1'b0;
            mon_rexp = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hxxxx_xxxx;
            chk("core_rdata", core_rdata, mon_rexp);
        end
        if (!rst && mem_req && !mem_busy) begin
            mon_obs = {mem_wr, mem_addr, mem_byte, mem_wr ? mem_wdata : 32'h0};
            mon_exp = (exp_mem.size() > 0) ? exp_mem.pop_front() : 69'bx;
            total++;
            assert (mon_obs === mon_exp) else begin
                bad++;
                $error("FAIL mem_xfer: got wr=%0b a=%0h be=%0h d=%0h want wr=%0b a=%0h be=%0h d=%0h",
                       mon_obs[68], mon_obs[67:36], mon_obs[35:32], mon_obs[31:0],
                       mon_exp[68], mon_exp[67:36], mon_exp[35:32], mon_exp[31:0]);
            end
            if (mem_wr) begin
                mon_old = cache.exists(mem_addr[31:2]) ? cache[mem_addr[31:2]] : 32'h0;
                cache[mem_addr[31:2]] = lanes(mon_old, mem_byte, mem_wdata);
            end else begin
                mrd_val  = cache.exists(mem_addr[31:2]) ? cache[mem_addr[31:2]] : 32'h0;
                mrd_pend = 1'b1;
            end
        end
        if (!rst && core_req && !core_wr && !core_busy) core_rd_pend = 1'b1;
    end

    // Cache read data appears the cycle after the read is accepted.
    always @(posedge clk) begin
        #1;
        if (mrd_pend) begin
            mem_rdata = mrd_val;
            mrd_pend  = 1'b0;
        end else begin
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    // Random cache back-pressure when enabled.
    always @(posedge clk) begin
        #2;
        if (rand_busy) mem_busy = 1'($urandom_range(0, 1));
    end

    task automatic core_op(input logic wr, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, input string tag);
        logic ok = 1'b0;
        core_req = 1'b1; core_wr = wr; core_addr = a; core_byte = be; core_wdata = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!core_busy) begin ok = 1'b1; break; end
        end
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        core_req = 1'b0; core_wr = 1'b0;
        if (ok && wr) gold[a[31:2]] = lanes(gold_rd(a), be, d);
    endtask

    task automatic wait_empty(input string tag);
        logic ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (wbuf_empty) begin ok = 1'b1; break; end
        end
        chk({tag, "_drained"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        rst = 1'b1; core_req = 1'b1; core_wr = 1'b0; core_addr = '0; core_byte = 4'hF;
        core_wdata = '0; mem_busy = 1'b0; mem_rdata = '0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_empty", 32'(wbuf_empty), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_core_busy", 32'(core_busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; core_req = 1'b0;
        @(negedge clk);
        chk("idle_core_busy", 32'(core_busy), 32'd0);
        @(posedge clk); #1;

        // fill to DEPTH while the cache stalls, then the fifth write waits for a drain
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h100 + 32'(4 * i);
            d = 32'hA000_0000 + 32'(i);
            exp_mem.push_back(mk(1'b1, a, 4'hF, d));
            core_op(1'b1, a, 4'hF, d, "fill");
        end
        exp_mem.push_back(mk(1'b1, 32'h110, 4'hF, 32'hA000_0004));
        core_req = 1'b1; core_wr = 1'b1; core_addr = 32'h110; core_byte = 4'hF;
        core_wdata = 32'hA000_0004;
        @(negedge clk);
        chk("full_busy0", 32'(core_busy), 32'd1);
        chk("full_not_empty", 32'(wbuf_empty), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_busy1", 32'(core_busy), 32'd1);
        @(posedge clk); #1;
        mem_busy = 1'b0;
        @(negedge clk);
        chk("full_deq_busy", 32'(core_busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_accept", 32'(core_busy), 32'd0);
        @(posedge clk); #1;
        core_req = 1'b0; core_wr = 1'b0;
        gold[32'h110 >> 2] = 32'hA000_0004;
        wait_empty("fill");

        // byte merge into a single stalled entry
        mem_busy = 1'b1;
        exp_mem.push_back(mk(1'b1, 32'h200, 4'b0101, 32'h0033_0011));
        core_op(1'b1, 32'h200, 4'b0001, 32'h0000_0011, "mrg0");
        core_op(1'b1, 32'h200, 4'b0100, 32'h0033_0000, "mrg1");
        @(negedge clk);
        chk("mrg_req", 32'(mem_req), 32'd1);
        chk("mrg_addr", mem_addr, 32'h200);
        chk("mrg_byte", 32'(mem_byte), 32'h5);
        chk("mrg_data", mem_wdata, 32'h0033_0011);
        @(posedge clk); #1;
        mem_busy = 1'b0;
        wait_empty("mrg");
        chk("mrg_single", 32'(exp_mem.size()), 32'd0);

        // read of a posted word waits for the drain and returns the new data
        mem_busy = 1'b1;
        exp_mem.push_back(mk(1'b1, 32'h300, 4'hF, 32'hCAFE_F00D));
        exp_mem.push_back(mk(1'b0, 32'h300, 4'hF, 32'h0));
        core_op(1'b1, 32'h300, 4'hF, 32'hCAFE_F00D, "haz_wr");
        exp_rd.push_back(gold_rd(32'h300));
        core_req = 1'b1; core_wr = 1'b0; core_addr = 32'h300; core_byte = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("haz_busy", 32'(core_busy), 32'd1);
            @(posedge clk); #1;
        end
        mem_busy = 1'b0;
        core_op(1'b0, 32'h300, 4'hF, 32'h0, "haz_rd");
        wait_empty("haz");

        // a non-hazard read goes ahead of a posted write
        exp_mem.push_back(mk(1'b1, 32'h500, 4'hF, 32'h5A5A_0500));
        core_op(1'b1, 32'h500, 4'hF, 32'h5A5A_0500, "pre");
        wait_empty("pre");
        mem_busy = 1'b1;
        exp_mem.push_back(mk(1'b0, 32'h500, 4'hF, 32'h0));
        exp_mem.push_back(mk(1'b1, 32'h400, 4'hF, 32'h4444_0400));
        core_op(1'b1, 32'h400, 4'hF, 32'h4444_0400, "ord_wr");
        exp_rd.push_back(gold_rd(32'h500));
        core_req = 1'b1; core_wr = 1'b0; core_addr = 32'h500; core_byte = 4'hF;
        mem_busy = 1'b0;
        @(negedge clk);
        chk("ord_rd_req", 32'(mem_req), 32'd1);
        chk("ord_rd_wr", 32'(mem_wr), 32'd0);
        chk("ord_rd_addr", mem_addr, 32'h500);
        chk("ord_rd_busy", 32'(core_busy), 32'd0);
        @(posedge clk); #1;
        core_req = 1'b0;
        @(negedge clk);
        chk("ord_wr_req", 32'(mem_req), 32'd1);
        chk("ord_wr_wr", 32'(mem_wr), 32'd1);
        chk("ord_wr_addr", mem_addr, 32'h400);
        @(posedge clk); #1;
        wait_empty("ord");

        // reset with three pending entries discards them
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core_op(1'b1, 32'h600 + 32'(4 * i), 4'hF, 32'h6600 + 32'(i), "rst_fill");
        end
        @(negedge clk);
        chk("rst_pre_empty", 32'(wbuf_empty), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_empty", 32'(wbuf_empty), 32'd1);
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(mem_req), 32'd0);
        end
        chk("rst_after_empty", 32'(wbuf_empty), 32'd1);
        @(posedge clk); #1;

        // DEPTH+3 back-to-back writes under random back-pressure
        rand_busy = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            a = 32'h700 + 32'(4 * i);
            d = $urandom;
            exp_mem.push_back(mk(1'b1, a, 4'hF, d));
            core_op(1'b1, a, 4'hF, d, "wrap");
        end
        wait_empty("wrap");
        rand_busy = 1'b0; mem_busy = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("exp_mem_left", 32'(exp_mem.size()), 32'd0);
        chk("exp_rd_left", 32'(exp_rd.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf.md
DMEM_WBUF -- requirements
Module: dmem_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of posted-write entries (power of two, >=2).
REQ-002 SHALL have parameter AW, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port core_req  input  1  core access request.
REQ-006 SHALL have port core_wr  input  1  1=write, 0=read.
REQ-007 SHALL have port core_addr  input  AW  byte address; word = core_addr[AW-1:2].
REQ-008 SHALL have port core_byte  input  4  byte-lane strobe.
REQ-009 SHALL have port core_wdata  input  32  write data.
REQ-010 SHALL have port core_rdata  output  32  read data, valid cycle after read acceptance.
REQ-011 SHALL have port core_busy  output  1  request not accepted this cycle.
REQ-012 SHALL have port mem_req  output  1  request to L1 data cache.
REQ-013 SHALL have port mem_wr  output  1  1=write, 0=read.
REQ-014 SHALL have port mem_addr  output  AW  byte address to cache.
REQ-015 SHALL have port mem_byte  output  4  byte-lane strobe to cache.
REQ-016 SHALL have port mem_wdata  output  32  write data to cache.
REQ-017 SHALL have port mem_rdata  input  32  cache read data, valid cycle after accepted read.
REQ-018 SHALL have port mem_busy  input  1  cache not accepting this cycle.
REQ-019 SHALL have port wbuf_empty  output  1  no posted writes pending (for fence/sfence).

Function
REQ-020 Handshake, both sides: transfer occurs in cycle with req=1 and busy=0; requester holds all request fields stable while busy=1.
REQ-021 Buffer: circular FIFO, head/tail pointers wrap modulo DEPTH, count 0..DEPTH; wbuf_empty = (count==0).
REQ-022 Write, no merge, count<DEPTH: core_busy=0, entry {word addr, byte, data} enqueued at tail.
REQ-023 Write, count==DEPTH: core_busy=1, no enqueue, even if head dequeues same cycle.
REQ-024 Merge: write word address equals youngest entry AND that entry not dequeuing this cycle -> core_busy=0, entry byte |= core_byte, strobed lanes overwritten with core_wdata, count unchanged; merge allowed when full.
REQ-025 Read hazard: read word address matches any valid entry -> core_busy=1, drain continues; read proceeds once no match.
REQ-026 Read, no hazard: pass-through, higher priority than drain; mem_req=1, mem_wr=0, mem_addr=core_addr, mem_byte=core_byte, core_busy=mem_busy; core_rdata=mem_rdata combinationally.
REQ-027 Drain: when no pass-through read, mem_req=(count>0), mem_wr=1, mem_addr={head addr,2'b00}, mem_byte/mem_wdata from head; head pops when ~mem_busy.
REQ-028 Drain entry fields SHALL stay stable while mem_busy=1 (no merge into the head entry while it is presented).
REQ-029 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-030 core_req=0: core_busy=0; buffer drains.
REQ-031 Ordering: writes reach cache in acceptance order; merged bytes never reorder relative to other words.

Reset
REQ-032 While rst=1: count=0, head=tail=0, entries invalid, mem_req=0, core_busy=1, wbuf_empty=1.
REQ-033 rst asserted mid-drain or mid-read: pending entries discarded, no further mem_req after assertion.
REQ-034 First request accepted earliest in the first clock edge after rst deasserts.

Verification
REQ-035 Four writes 0x100,0x104,0x108,0x10C with mem_busy=1 -> all accepted, count=4; fifth write 0x110 -> core_busy=1 until mem_busy drops and one entry drains.
REQ-036 Write 0x200 byte=4'b0001 data=0x11, then 0x200 byte=4'b0100 data=0x00330000 while mem_busy=1 -> one entry, byte=4'b0101, data lanes 0x00330011; after drain single mem write.
REQ-037 Posted write 0x300, then read 0x300 -> core_busy=1 until write accepted by cache; read then returns new data next cycle.
REQ-038 Posted write 0x400, read 0x500, mem_busy=0 -> read issued first (mem_wr=0, mem_addr=0x500), write drains following cycle.
REQ-039 Three entries pending, pulse rst -> wbuf_empty=1, mem_req=0, no stale write issued after release.
REQ-040 DEPTH+3 back-to-back writes with random mem_busy -> cache sees exact address/data sequence, pointers wrap correctly.
